rr_arbiter4: RTL

Four-requester round-robin arbiter that shares one downstream resource (e.g. a single transaction port) among `req[3:0]`. It selects the winner with a rotating-priority 4-to-1 encode, registers a one-hot grant, and holds the grant until the owner finishes, drops its request, or exceeds a hold limit. It sits between the requesting masters and the shared resource.

---
 rtl/rr_arbiter4.sv | 90 +++++++++
 1 files changed

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a registered one-hot grant, done/drop
// release and a bounded hold time that forces a handover after MAX_HOLD cycles.
module rr_arbiter4 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_HOLD);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t        state;
  logic [1:0]    ptr;
  logic [CW-1:0] cnt;

  logic [1:0] win;
  logic [1:0] idx;
  logic       found;
  logic       any_req;
  logic       at_limit;
  logic       rel;
  logic       do_grant;
  logic       go_idle;

  // Rotating-priority encode: first requester at or after ptr, wrapping mod 4.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    win   = 2'd0;
    idx   = 2'd0;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    any_req  = |req;
    at_limit = (cnt == MAX_CNT);
    rel      = done | ~req[gnt_id] | at_limit;
    do_grant = any_req & ((state == IDLE) | rel);
    go_idle  = (state == OWNED) & rel & ~any_req;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      cnt       <= '0;
      gnt       <= 4'd0;
      gnt_id    <= 2'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      // A forced release only counts when neither done nor a request drop explains it.
      timeout <= (state == OWNED) & at_limit & ~done & req[gnt_id];
      if (do_grant) begin
        state     <= OWNED;
        gnt       <= 4'(1) << win;
        gnt_id    <= win;
        gnt_valid <= 1'b1;
        ptr       <= win + 2'd1;
        cnt       <= CW'(1);
      end else if (go_idle) begin
        state     <= IDLE;
        gnt       <= 4'd0;
        gnt_id    <= 2'd0;
        gnt_valid <= 1'b0;
        cnt       <= '0;
      end else if (state == OWNED) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule
